// File: rtl/ncl_count_capture.sv
// Clocked completion stage for the NCL dual-rail ring counter: synchronizes the
// sum/carry rails, acknowledges DATA/NULL wavefronts and buffers each count.
module ncl_count_capture #(
  parameter int W           = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           init_n,
  input  logic [2*W-1:0] sum_in,
  input  logic [1:0]     cout_in,
  output logic           sum_comp,
  output logic           cout_comp,
  output logic [W-1:0]   out_value,
  output logic           out_wrap,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           rail_err,
  output logic           seq_err
);

  localparam int R = 2*W + 2;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0][R-1:0] sync_q, sync_d;
  logic [R-1:0]                  rails;
  logic                          all_data_q, all_data_d;
  logic                          all_null_q, all_null_d;
  logic                          rail_bad_d;
  state_t                        state_q, state_d;
  logic [W-1:0]                  out_value_q, out_value_d;
  logic                          out_wrap_q, out_wrap_d;
  logic                          out_valid_q, out_valid_d;
  logic                          have_prev_q, have_prev_d;
  logic                          rail_err_q, rail_err_d;
  logic                          seq_err_q, seq_err_d;
  logic                          capture;
  logic [W-1:0]                  value_w;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {cout_in, sum_in};
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign rails = sync_q[SYNC_STAGES-1];

  // Digit W is the carryout; it takes part in completion like any sum digit.
  always_comb begin
    all_data_d = 1'b1;
    all_null_d = ~|rails;
    rail_bad_d = 1'b0;
    value_w    = '0;
    for (int i = 0; i <= W; i++) begin
      if (rails[2*i +: 2] != 2'b01 && rails[2*i +: 2] != 2'b10) all_data_d = 1'b0;
      if (rails[2*i +: 2] == 2'b11) rail_bad_d = 1'b1;
    end
    for (int i = 0; i < W; i++) begin
      value_w[i] = rails[2*i+1];
    end
  end

  assign capture = (state_q == WAIT_DATA) && all_data_q && (!out_valid_q || out_ready);

  // out_value_q doubles as the previous count: it only ever changes on capture.
  always_comb begin
    state_d     = state_q;
    out_value_d = out_value_q;
    out_wrap_d  = out_wrap_q;
    out_valid_d = out_valid_q;
    have_prev_d = have_prev_q;
    rail_err_d  = rail_err_q | rail_bad_d;
    seq_err_d   = seq_err_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        if (capture) begin
          out_value_d = value_w;
          out_wrap_d  = rails[2*W+1];
          out_valid_d = 1'b1;
          have_prev_d = 1'b1;
          if (have_prev_q && (value_w != out_value_q + W'(1))) seq_err_d = 1'b1;
          state_d = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (all_null_q) state_d = WAIT_DATA;
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      sync_q      <= '0;
      all_data_q  <= 1'b0;
      all_null_q  <= 1'b0;
      state_q     <= WAIT_DATA;
      out_value_q <= '0;
      out_wrap_q  <= 1'b0;
      out_valid_q <= 1'b0;
      have_prev_q <= 1'b0;
      rail_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      all_data_q  <= all_data_d;
      all_null_q  <= all_null_d;
      state_q     <= state_d;
      out_value_q <= out_value_d;
      out_wrap_q  <= out_wrap_d;
      out_valid_q <= out_valid_d;
      have_prev_q <= have_prev_d;
      rail_err_q  <= rail_err_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign sum_comp  = (state_q == WAIT_NULL);
  assign cout_comp = sum_comp;
  assign out_value = out_value_q;
  assign out_wrap  = out_wrap_q;
  assign out_valid = out_valid_q;
  assign rail_err  = rail_err_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_ncl_count_capture.sv
// Bench for ncl_count_capture: drives dual-rail wavefronts and scoreboards the
// captured words against the values and carryouts that were presented.
module tb_ncl_count_capture;

  localparam int W  = 32;
  localparam int SS = 2;

  logic           clk = 1'b0;
  logic           init_n;
  logic [2*W-1:0] sum_in;
  logic [1:0]     cout_in;
  logic           sum_comp, cout_comp;
  logic [W-1:0]   out_value;
  logic           out_wrap, out_valid, out_ready;
  logic           rail_err, seq_err;

  logic [W:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit rand_ready = 1'b0;

  ncl_count_capture #(.W(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .init_n(init_n), .sum_in(sum_in), .cout_in(cout_in),
    .sum_comp(sum_comp), .cout_comp(cout_comp), .out_value(out_value),
    .out_wrap(out_wrap), .out_valid(out_valid), .out_ready(out_ready),
    .rail_err(rail_err), .seq_err(seq_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) r[2*i +: 2] = {v[i], ~v[i]};
    return r;
  endfunction

  // scoreboard: a handshake completes on the edge after a negedge with valid&ready
  always @(negedge clk) begin
    if (init_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("sb_word", 64'({out_wrap, out_value}), 64'(e));
      end
    end
  end

  // driver tasks: entered and left at posedge+2
  task automatic wait_comp(input logic lvl, input string tag);
    int n = 0;
    while (sum_comp !== lvl && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (rand_ready && !out_ready && $urandom_range(0, 3) == 0) out_ready = 1'b1;
    end
    check(tag, 64'(sum_comp), 64'(lvl));
    #1;
  endtask

  task automatic send_data(input logic [W-1:0] v, input logic c);
    sum_in  = enc(v);
    cout_in = {c, ~c};
    exp_q.push_back({c, v});
    wait_comp(1'b1, "data_ack");
  endtask

  task automatic send_null();
    sum_in  = '0;
    cout_in = 2'b00;
    wait_comp(1'b0, "null_ack");
  endtask

  task automatic do_reset();
    init_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 init_n = 1'b1;
  endtask

  initial begin
    logic [2*W-1:0] bad;
    init_n    = 1'b0;
    sum_in    = enc(32'h33);
    cout_in   = 2'b01;
    out_ready = 1'b1;

    // reset held with DATA present
    repeat (5) @(posedge clk);
    #1;
    check("rst_sum_comp", 64'(sum_comp), 64'd0);
    check("rst_cout_comp", 64'(cout_comp), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_value", 64'({out_wrap, out_value}), 64'd0);
    check("rst_errs", 64'({rail_err, seq_err}), 64'd0);
    exp_q.push_back({1'b0, 32'h33});
    #1 init_n = 1'b1;
    wait_comp(1'b1, "rst_first_cap");
    check("rst_first_valid", 64'(out_valid), 64'd1);
    check("rst_first_seq", 64'(seq_err), 64'd0);
    send_null();
    do_reset();

    // single wavefront with exact latencies
    @(posedge clk); #2;
    sum_in = enc(32'h5); cout_in = 2'b01;
    exp_q.push_back({1'b0, 32'h5});
    repeat (3) begin @(posedge clk); #1; end
    check("single_edge3", 64'(sum_comp), 64'd0);
    @(posedge clk); #1;
    check("single_edge4", 64'(sum_comp), 64'd1);
    check("single_cout_comp", 64'(cout_comp), 64'd1);
    check("single_value", 64'(out_value), 64'h5);
    #1;
    sum_in = '0; cout_in = 2'b00;
    repeat (3) begin @(posedge clk); #1; end
    check("null_edge3", 64'(sum_comp), 64'd1);
    @(posedge clk); #1;
    check("null_edge4", 64'(sum_comp), 64'd0);
    #1;

    // backpressure
    out_ready = 1'b0;
    send_data(32'h6, 1'b0);
    send_null();
    sum_in = enc(32'h7); cout_in = 2'b01;
    exp_q.push_back({1'b0, 32'h7});
    repeat (10) begin @(posedge clk); #1; end
    check("bp_stall", 64'(sum_comp), 64'd0);
    check("bp_hold_value", 64'(out_value), 64'h6);
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drain_cap", 64'(sum_comp), 64'd1);
    check("bp_drain_valid", 64'(out_valid), 64'd1);
    check("bp_drain_value", 64'(out_value), 64'h7);
    #1;
    send_null();

    // random gaps and ready stalls on a consecutive run
    rand_ready = 1'b1;
    for (int k = 8; k < 20; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_data(32'(k), 1'b0);
      send_null();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rand_seq", 64'(seq_err), 64'd0);

    // wrap
    do_reset();
    send_data(32'hFFFF_FFFE, 1'b0); send_null();
    send_data(32'hFFFF_FFFF, 1'b0); send_null();
    send_data(32'h0, 1'b1);
    check("wrap_flag", 64'(out_wrap), 64'd1);
    check("wrap_value", 64'(out_value), 64'h0);
    check("wrap_seq", 64'(seq_err), 64'd0);
    send_null();

    // skip
    do_reset();
    send_data(32'h10, 1'b0);
    check("skip_first", 64'(seq_err), 64'd0);
    send_null();
    send_data(32'h12, 1'b0);
    check("skip_detect", 64'(seq_err), 64'd1);
    send_null();
    send_data(32'h13, 1'b0);
    check("skip_sticky", 64'(seq_err), 64'd1);
    send_null();

    // illegal rail on digit 3
    do_reset();
    bad = enc(32'h55);
    bad[7:6] = 2'b11;
    sum_in = bad; cout_in = 2'b01;
    repeat (SS) begin @(posedge clk); #1; end
    check("rail_pre", 64'(rail_err), 64'd0);
    @(posedge clk); #1;
    check("rail_detect", 64'(rail_err), 64'd1);
    repeat (10) begin @(posedge clk); #1; end
    check("rail_no_ack", 64'(sum_comp), 64'd0);
    check("rail_no_cap", 64'(out_valid), 64'd0);
    #1 sum_in = '0; cout_in = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    check("rail_sticky", 64'(rail_err), 64'd1);
    #1;
    do_reset();
    #1;
    check("rail_cleared", 64'(rail_err), 64'd0);
    #1;

    // reset while in WAIT_NULL with DATA still held
    send_data(32'h40, 1'b0);
    init_n = 1'b0;
    exp_q.delete();
    #1;
    check("wn_rst_comp", 64'(sum_comp), 64'd0);
    check("wn_rst_valid", 64'(out_valid), 64'd0);
    check("wn_rst_value", 64'(out_value), 64'd0);
    exp_q.push_back({1'b0, 32'h40});
    repeat (2) @(posedge clk);
    #2 init_n = 1'b1;
    wait_comp(1'b1, "wn_recap");
    check("wn_recap_value", 64'(out_value), 64'h40);
    check("wn_recap_seq", 64'(seq_err), 64'd0);
    send_null();

    repeat (5) @(posedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
